// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;
  localparam int unsigned SAMPLE_BITS = 24;

  typedef logic [SAMPLE_BITS-1:0] sample_t;

  localparam logic CH_LEFT  = 1'b1;
  localparam logic CH_RIGHT = 1'b0;
endpackage

// File: rtl/i2s_ws_edge.sv
// Word-select tracker: registers ws, flags a slot boundary, arms on the first boundary.
module i2s_ws_edge
  import i2s_pkg::*;
(
  input  logic i_sck,
  input  logic i_rst,
  input  logic i_ws,
  output logic o_ws_q,
  output logic o_edge_c,
  output logic o_armed
);

  logic r_ws_q;
  logic r_armed;

  // ws_q resets high so a receiver started in the left slot sees an edge immediately.
  always_ff @(posedge i_sck) begin
    if (i_rst) begin
      r_ws_q  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_ws_q <= i_ws;
      if (o_edge_c) r_armed <= 1'b1;
    end
  end

  assign o_edge_c = i_ws ^ r_ws_q;
  assign o_ws_q   = r_ws_q;
  assign o_armed  = r_armed;

endmodule

// File: rtl/i2s_in.sv
// I2S serial receiver: deserializes MSB-first slots into words with a channel tag and strobe.
// Optional frame_err output (slot length != word width) is enabled by defining I2SIN_FRAME_ERR_EN.
module i2s_in
  import i2s_pkg::*;
#(
  parameter int unsigned BITS_PRECISION = SAMPLE_BITS
) (
  input  logic                      sck,
  input  logic                      rst,
  input  logic                      ws,
  input  logic                      sd,
  output logic [BITS_PRECISION-1:0] data_in,
  output logic                      left_rightn,
  output logic                      data_en
`ifdef I2SIN_FRAME_ERR_EN
  ,
  output logic                      frame_err
`endif
);

  localparam int unsigned CW = $clog2(BITS_PRECISION + 1);

  logic                      w_ws_q;
  logic                      w_edge;
  logic                      w_armed;
  logic [BITS_PRECISION-1:0] w_full;
  logic [BITS_PRECISION-1:0] w_word;
  logic [CW-1:0]             w_pad;

  logic [BITS_PRECISION-1:0] r_shift;
  logic [CW-1:0]             r_count;
  logic [BITS_PRECISION-1:0] r_data_in;
  logic                      r_left_rightn;
  logic                      r_data_en;

  i2s_ws_edge u_ws_edge (
    .i_sck    (sck),
    .i_rst    (rst),
    .i_ws     (ws),
    .o_ws_q   (w_ws_q),
    .o_edge_c (w_edge),
    .o_armed  (w_armed)
  );

  assign w_full = {r_shift[BITS_PRECISION-2:0], sd};
  assign w_pad  = CW'(BITS_PRECISION - 1) - r_count;

  // Exact slot takes the edge bit as LSB; long slot keeps the frozen first word; short slot left-justifies.
  always_comb begin
    w_word = w_full;
    if (r_count >= CW'(BITS_PRECISION)) begin
      w_word = r_shift;
    end else if (r_count != CW'(BITS_PRECISION - 1)) begin
      w_word = w_full << w_pad;
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      r_shift       <= '0;
      r_count       <= '0;
      r_data_in     <= '0;
      r_left_rightn <= 1'b0;
      r_data_en     <= 1'b0;
    end else begin
      r_data_en <= 1'b0;
      if (w_edge) begin
        if (w_armed) begin
          r_data_in     <= w_word;
          r_left_rightn <= w_ws_q ? CH_RIGHT : CH_LEFT;
          r_data_en     <= 1'b1;
        end
        r_shift <= '0;
        r_count <= '0;
      end else if (r_count < CW'(BITS_PRECISION)) begin
        r_shift <= w_full;
        r_count <= r_count + CW'(1);
      end
    end
  end

`ifdef I2SIN_FRAME_ERR_EN
  logic r_frame_err;

  always_ff @(posedge sck) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_edge && w_armed && (r_count != CW'(BITS_PRECISION - 1));
    end
  end

  assign frame_err = r_frame_err;
`endif

  assign data_in     = r_data_in;
  assign left_rightn = r_left_rightn;
  assign data_en     = r_data_en;

endmodule

// File: tb/tb_i2s_in.sv
// Directed self-checking bench for i2s_in (24-bit default build, optional frame_err).
module tb_i2s_in;
  import i2s_pkg::*;

  logic    sck = 1'b0;
  logic    rst = 1'b1;
  logic    ws  = 1'b1;
  logic    sd  = 1'b0;
  sample_t data_in;
  logic    left_rightn;
  logic    data_en;
`ifdef I2SIN_FRAME_ERR_EN
  logic    frame_err;
`endif

  int checks    = 0;
  int errors    = 0;
  int n_strobes = 0;
  int cyc       = 0;

  i2s_in dut (
    .sck         (sck),
    .rst         (rst),
    .ws          (ws),
    .sd          (sd),
    .data_in     (data_in),
    .left_rightn (left_rightn),
    .data_en     (data_en)
`ifdef I2SIN_FRAME_ERR_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  always #5 sck = ~sck;

  always @(posedge sck) cyc++;
  always @(negedge sck) if (data_en === 1'b1) n_strobes++;

  task automatic send_bit(input logic b_ws, input logic b_sd);
    @(negedge sck);
    ws = b_ws;
    sd = b_sd;
    @(posedge sck);
    #1;
  endtask

  // Slot of n bits MSB first; ws flips to nxt on the LSB, as I2S does.
  task automatic send_slot(input logic cur, input logic nxt, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? nxt : cur, val[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ws  = 1'b1;
    sd  = 1'b0;
    repeat (3) @(posedge sck);
    #1;
    checks++; if (data_in !== 24'h0) begin errors++; $display("FAIL reset_data got %h want %h", data_in, 24'h0); end
    checks++; if (left_rightn !== 1'b0) begin errors++; $display("FAIL reset_lr got %b want 0", left_rightn); end
    checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", data_en); end
`ifdef I2SIN_FRAME_ERR_EN
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
`endif
    @(negedge sck);
    rst = 1'b0;
  endtask

  task automatic test_first_word();
    int base;
    base = n_strobes;
    repeat (3) send_bit(1'b1, 1'b0);
    send_slot(1'b1, 1'b0, 32'hFFFFFF, 24);
    checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL arm_only_en got %b want 0", data_en); end
    checks++; if (data_in !== 24'h0) begin errors++; $display("FAIL arm_only_data got %h want 000000", data_in); end
    send_slot(1'b0, 1'b1, 32'h000001, 24);
    checks++; if (data_en !== 1'b1) begin errors++; $display("FAIL first_en got %b want 1", data_en); end
    checks++; if (data_in !== 24'h000001) begin errors++; $display("FAIL first_data got %h want 000001", data_in); end
    checks++; if (left_rightn !== CH_LEFT) begin errors++; $display("FAIL first_lr got %b want 1", left_rightn); end
`ifdef I2SIN_FRAME_ERR_EN
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL first_ferr got %b want 0", frame_err); end
`endif
    send_slot(1'b1, 1'b0, 32'h000002, 24);
    checks++; if (data_en !== 1'b1 || data_in !== 24'h000002 || left_rightn !== CH_RIGHT) begin
      errors++; $display("FAIL second_word got en=%b data=%h lr=%b want 1/000002/0", data_en, data_in, left_rightn);
    end
    checks++; if (n_strobes - base !== 1) begin errors++; $display("FAIL first_strobes got %0d want 1", n_strobes - base); end
  endtask

  task automatic test_stream();
    int t_prev;
    t_prev = cyc;
    for (int k = 0; k < 3; k++) begin
      send_slot(1'b0, 1'b1, 32'hABCDEF, 24);
      checks++; if (data_en !== 1'b1 || data_in !== 24'hABCDEF || left_rightn !== CH_LEFT) begin
        errors++; $display("FAIL stream_left%0d got en=%b data=%h lr=%b want 1/abcdef/1", k, data_en, data_in, left_rightn);
      end
      checks++; if (cyc - t_prev !== 24) begin errors++; $display("FAIL stream_left_gap%0d got %0d want 24", k, cyc - t_prev); end
      t_prev = cyc;
      send_slot(1'b1, 1'b0, 32'h123456, 24);
      checks++; if (data_en !== 1'b1 || data_in !== 24'h123456 || left_rightn !== CH_RIGHT) begin
        errors++; $display("FAIL stream_right%0d got en=%b data=%h lr=%b want 1/123456/0", k, data_en, data_in, left_rightn);
      end
      checks++; if (cyc - t_prev !== 24) begin errors++; $display("FAIL stream_right_gap%0d got %0d want 24", k, cyc - t_prev); end
      t_prev = cyc;
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [23:0] rv;
    rv = 24'h654321;
    send_slot(1'b0, 1'b1, 32'h111111, 24);
    for (int i = 23; i >= 14; i--) send_bit(1'b1, rv[i]);
    @(negedge sck);
    rst = 1'b1;
    @(posedge sck);
    #1;
    checks++; if (data_in !== 24'h0 || left_rightn !== 1'b0 || data_en !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got data=%h lr=%b en=%b want 000000/0/0", data_in, left_rightn, data_en);
    end
    @(negedge sck);
    rst = 1'b0;
    base = n_strobes;
    for (int i = 13; i >= 0; i--) send_bit((i == 0) ? 1'b0 : 1'b1, rv[i]);
    checks++; if (data_en !== 1'b0 || data_in !== 24'h0) begin
      errors++; $display("FAIL midrst_rearm got en=%b data=%h want 0/000000", data_en, data_in);
    end
    send_slot(1'b0, 1'b1, 32'h0A0B0C, 24);
    checks++; if (data_en !== 1'b1 || data_in !== 24'h0A0B0C || left_rightn !== CH_LEFT) begin
      errors++; $display("FAIL midrst_word got en=%b data=%h lr=%b want 1/0a0b0c/1", data_en, data_in, left_rightn);
    end
    checks++; if (n_strobes !== base) begin errors++; $display("FAIL midrst_strobes got %0d want %0d", n_strobes, base); end
  endtask

  task automatic test_short_slot();
    send_slot(1'b1, 1'b0, 32'hFFFFF, 20);
    checks++; if (data_en !== 1'b1 || data_in !== 24'hFFFFF0 || left_rightn !== CH_RIGHT) begin
      errors++; $display("FAIL short_word got en=%b data=%h lr=%b want 1/fffff0/0", data_en, data_in, left_rightn);
    end
`ifdef I2SIN_FRAME_ERR_EN
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_ferr got %b want 1", frame_err); end
`endif
  endtask

  task automatic test_long_slot();
    send_slot(1'b0, 1'b1, 32'h800001F, 28);
    checks++; if (data_en !== 1'b1 || data_in !== 24'h800001 || left_rightn !== CH_LEFT) begin
      errors++; $display("FAIL long_word got en=%b data=%h lr=%b want 1/800001/1", data_en, data_in, left_rightn);
    end
`ifdef I2SIN_FRAME_ERR_EN
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL long_ferr got %b want 1", frame_err); end
`endif
    send_slot(1'b1, 1'b0, 32'h55AA33, 24);
    checks++; if (data_en !== 1'b1 || data_in !== 24'h55AA33 || left_rightn !== CH_RIGHT) begin
      errors++; $display("FAIL after_long_word got en=%b data=%h lr=%b want 1/55aa33/0", data_en, data_in, left_rightn);
    end
`ifdef I2SIN_FRAME_ERR_EN
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL after_long_ferr got %b want 0", frame_err); end
`endif
  endtask

  task automatic test_no_edge();
    int base;
    int seen;
    seen = 0;
    send_bit(1'b0, 1'b1);
    base = n_strobes;
    for (int i = 0; i < 100; i++) begin
      send_bit(1'b0, 1'(i % 3 == 0));
      if (data_en !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL noedge_en got %0d high cycles want 0", seen); end
    checks++; if (n_strobes !== base) begin errors++; $display("FAIL noedge_strobes got %0d want %0d", n_strobes, base); end
    checks++; if (data_in !== 24'h55AA33) begin errors++; $display("FAIL noedge_hold got %h want 55aa33", data_in); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_stream();
    test_reset_mid();
    test_short_slot();
    test_long_slot();
    test_no_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
